// File: rtl/mem_periph_responder.sv
// Data-memory responder: word RAM plus memory-mapped timer/IRQ, LED, switch, 7-seg and tick counter.
// Reads are combinational (0 cycles), writes land on the next rising edge; no backpressure, always ready.
module mem_periph_responder #(
  parameter int RAM_AW = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] iAddr,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iWriteData,
  output logic [31:0] oReadData,
  input  logic [7:0]  iSwitch,
  output logic [7:0]  oLED,
  output logic [11:0] oDigi,
  output logic        oIRQ
);

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_DIGI = 32'h4000_0014;
  localparam logic [31:0] A_TICK = 32'h4000_0018;

  logic [31:0]       addr_al;
  logic              sel_ram;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_ram, wr_th, wr_tl, wr_tcon, wr_led, wr_digi;

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic [31:0] tick_q;
  logic [7:0]  sw_meta_q, sw_sync_q;
  logic        tl_ovf;
  logic [31:0] rd_val;

  logic [31:0] ram [0:(2**RAM_AW)-1];

  // Byte-offset bits are dropped; upper RAM address bits are ignored so the RAM aliases.
  assign addr_al = iAddr & 32'hFFFF_FFFC;
  assign sel_ram = (addr_al[31:30] == 2'b00);
  assign ram_idx = addr_al[RAM_AW+1:2];

  assign wr_ram  = iMemWrite && sel_ram;
  assign wr_th   = iMemWrite && (addr_al == A_TH);
  assign wr_tl   = iMemWrite && (addr_al == A_TL);
  assign wr_tcon = iMemWrite && (addr_al == A_TCON);
  assign wr_led  = iMemWrite && (addr_al == A_LED);
  assign wr_digi = iMemWrite && (addr_al == A_DIGI);

  assign tl_ovf = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);

  // A software write wins for its own register; overflow still sets status if TCON is untouched.
  always_comb begin
    th_d   = wr_th   ? iWriteData        : th_q;
    led_d  = wr_led  ? iWriteData[7:0]   : led_q;
    digi_d = wr_digi ? iWriteData[11:0]  : digi_q;
    tl_d   = tl_q;
    if (wr_tl)          tl_d = iWriteData;
    else if (tl_ovf)    tl_d = th_q;
    else if (tcon_q[0]) tl_d = tl_q + 32'd1;
    tcon_d = tcon_q;
    if (wr_tcon)        tcon_d = iWriteData[2:0];
    else if (tl_ovf)    tcon_d = tcon_q | 3'b100;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q      <= 32'h0;
      tl_q      <= 32'h0;
      tcon_q    <= 3'h0;
      led_q     <= 8'h0;
      digi_q    <= 12'h0;
      tick_q    <= 32'h0;
      sw_meta_q <= 8'h0;
      sw_sync_q <= 8'h0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digi_q    <= digi_d;
      tick_q    <= tick_q + 32'd1;
      sw_meta_q <= iSwitch;
      sw_sync_q <= sw_meta_q;
    end
  end

  // RAM keeps its contents through reset, but a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset && wr_ram) begin
      ram[ram_idx] <= iWriteData;
    end
  end

  always_comb begin
    rd_val = 32'h0;
    if (sel_ram) begin
      rd_val = ram[ram_idx];
    end else begin
      case (addr_al)
        A_TH:    rd_val = th_q;
        A_TL:    rd_val = tl_q;
        A_TCON:  rd_val = {29'h0, tcon_q};
        A_LED:   rd_val = {24'h0, led_q};
        A_SW:    rd_val = {24'h0, sw_sync_q};
        A_DIGI:  rd_val = {20'h0, digi_q};
        A_TICK:  rd_val = tick_q;
        default: rd_val = 32'h0;
      endcase
    end
  end

  assign oReadData = iMemRead ? rd_val : 32'h0;
  assign oLED      = led_q;
  assign oDigi     = digi_q;
  assign oIRQ      = tcon_q[1] & tcon_q[2];

endmodule

// File: tb/tb_mem_periph_responder.sv
// Scoreboard bench: driver pushes model-predicted read data; a negedge monitor pops and compares.
module tb_mem_periph_responder;

  localparam int RAM_AW = 8;
  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_DIGI = 32'h4000_0014;
  localparam logic [31:0] A_TICK = 32'h4000_0018;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] iAddr = 32'h0;
  logic        iMemRead = 1'b0;
  logic        iMemWrite = 1'b0;
  logic [31:0] iWriteData = 32'h0;
  logic [31:0] oReadData;
  logic [7:0]  iSwitch = 8'h0;
  logic [7:0]  oLED;
  logic [11:0] oDigi;
  logic        oIRQ;

  mem_periph_responder #(.RAM_AW(RAM_AW)) dut (
    .clk(clk), .reset(reset), .iAddr(iAddr), .iMemRead(iMemRead),
    .iMemWrite(iMemWrite), .iWriteData(iWriteData), .oReadData(oReadData),
    .iSwitch(iSwitch), .oLED(oLED), .oDigi(oDigi), .oIRQ(oIRQ)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_th = 0, m_tl = 0, m_tick = 0;
  logic [2:0]  m_tcon = 0;
  logic [7:0]  m_led = 0, m_sw1 = 0, m_sw2 = 0;
  logic [11:0] m_digi = 0;
  logic [31:0] m_ram [int];

  logic [31:0] exp_q [$];
  string       nm_q [$];
  int          n_chk = 0, n_pass = 0, n_fail = 0;
  logic        mon_en = 1'b0;

  function automatic int ram_index(input logic [31:0] a);
    return int'((a >> 2) % (32'd1 << RAM_AW));
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a_in);
    logic [31:0] a;
    a = a_in & 32'hFFFF_FFFC;
    if (a[31:30] == 2'b00) return m_ram.exists(ram_index(a)) ? m_ram[ram_index(a)] : 32'h0;
    case (a)
      A_TH:    return m_th;
      A_TL:    return m_tl;
      A_TCON:  return {29'h0, m_tcon};
      A_LED:   return {24'h0, m_led};
      A_SW:    return {24'h0, m_sw2};
      A_DIGI:  return {20'h0, m_digi};
      A_TICK:  return m_tick;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0;
    m_tick = 0; m_sw1 = 0; m_sw2 = 0;
  endtask

  task automatic model_step();
    logic [31:0] a, nth, ntl;
    logic [2:0]  ntcon;
    logic        ovf;
    if (!reset) begin
      model_clear();
      return;
    end
    a     = iAddr & 32'hFFFF_FFFC;
    ovf   = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
    nth   = m_th;
    ntl   = m_tcon[0] ? (ovf ? m_th : m_tl + 32'd1) : m_tl;
    ntcon = ovf ? (m_tcon | 3'b100) : m_tcon;
    if (iMemWrite) begin
      if (a[31:30] == 2'b00) m_ram[ram_index(a)] = iWriteData;
      else begin
        case (a)
          A_TH:    nth = iWriteData;
          A_TL:    ntl = iWriteData;
          A_TCON:  ntcon = iWriteData[2:0];
          A_LED:   m_led = iWriteData[7:0];
          A_DIGI:  m_digi = iWriteData[11:0];
          default: ;
        endcase
      end
    end
    m_th = nth; m_tl = ntl; m_tcon = ntcon;
    m_tick = m_tick + 32'd1;
    m_sw2 = m_sw1;
    m_sw1 = iSwitch;
  endtask

  always @(posedge clk) model_step();

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) check(nm_q.pop_front(), oReadData, exp_q.pop_front());
      check("oLED", {24'h0, oLED}, {24'h0, m_led});
      check("oDigi", {20'h0, oDigi}, {20'h0, m_digi});
      check("oIRQ", {31'h0, oIRQ}, {31'h0, m_tcon[1] & m_tcon[2]});
    end
  end

  task automatic cyc(input logic r, input logic [31:0] a, input logic rd, input logic wr,
                     input logic [31:0] wd, input string nm);
    @(posedge clk);
    #1;
    reset = r;
    if (!r) model_clear();
    iAddr = a; iMemRead = rd; iMemWrite = wr; iWriteData = wd;
    exp_q.push_back(rd ? model_read(a) : 32'h0);
    nm_q.push_back(nm);
    mon_en = 1'b1;
  endtask

  logic [31:0] addrs [10] = '{A_TH, A_TL, A_TCON, A_LED, A_SW, A_DIGI, A_TICK,
                              32'h4000_001C, 32'h8000_0010, 32'hC000_0000};

  initial begin
    #400000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, wd;
    logic        rd, wr;
    repeat (2) @(posedge clk);
    cyc(0, A_TL, 1, 0, 0, "rst_tl");
    cyc(0, A_TICK, 1, 0, 0, "rst_tick");
    cyc(1, A_TCON, 1, 0, 0, "rst_tcon");
    // RAM write, readback, alias, read strobe low
    cyc(1, 32'h10, 0, 1, 32'hDEAD_BEEF, "ram_wr");
    cyc(1, 32'h10, 1, 0, 0, "ram_rd");
    cyc(1, 32'h410, 1, 0, 0, "ram_alias");
    cyc(1, 32'h10, 0, 0, 0, "ram_nord");
    // Timer overflow with IRQ enabled
    cyc(1, A_TH, 0, 1, 32'hFFFF_FFFC, "th_wr");
    cyc(1, A_TL, 0, 1, 32'hFFFF_FFFE, "tl_wr");
    cyc(1, A_TCON, 0, 1, 32'h3, "tcon_wr");
    repeat (3) cyc(1, A_TL, 1, 0, 0, "tl_cnt");
    cyc(1, A_TCON, 1, 0, 0, "tcon_ovf");
    repeat (2) cyc(1, A_TCON, 1, 0, 0, "tcon_hold");
    cyc(1, A_TCON, 1, 1, 32'h3, "tcon_clr");
    cyc(1, A_TCON, 1, 0, 0, "tcon_after_clr");
    // Masked overflow
    cyc(1, A_TCON, 0, 1, 32'h0, "tcon_stop");
    cyc(1, A_TL, 0, 1, 32'hFFFF_FFFE, "tl_wr2");
    cyc(1, A_TCON, 0, 1, 32'h1, "tcon_wr1");
    repeat (3) cyc(1, A_TCON, 1, 0, 0, "tcon_masked");
    cyc(1, A_TL, 1, 0, 0, "tl_masked");
    // Peripheral registers
    cyc(1, A_LED, 0, 1, 32'h1A5, "led_wr");
    cyc(1, A_DIGI, 0, 1, 32'hFABC, "digi_wr");
    cyc(1, A_LED, 1, 0, 0, "led_rd");
    cyc(1, A_DIGI, 1, 0, 0, "digi_rd");
    cyc(1, A_TICK, 0, 1, 32'h0, "tick_wr");
    cyc(1, A_TICK, 1, 0, 0, "tick_rd");
    cyc(1, 32'h4000_001C, 1, 0, 0, "unmapped_rd");
    // Switch synchronizer
    cyc(1, A_SW, 1, 0, 0, "sw_base");
    iSwitch = 8'h3C;
    cyc(1, A_SW, 1, 0, 0, "sw_0edge");
    cyc(1, A_SW, 1, 0, 0, "sw_1edge");
    cyc(1, A_SW, 1, 0, 0, "sw_2edge");
    // Asynchronous reset mid-count
    cyc(1, A_TCON, 0, 1, 32'h3, "tcon_run");
    repeat (3) cyc(1, A_TL, 1, 0, 0, "tl_run");
    cyc(0, A_TL, 1, 0, 0, "arst_tl");
    cyc(0, A_TCON, 1, 0, 0, "arst_tcon");
    cyc(0, A_LED, 1, 0, 0, "arst_led");
    cyc(0, A_DIGI, 1, 0, 0, "arst_digi");
    cyc(0, A_TICK, 1, 0, 0, "arst_tick");
    cyc(0, 32'h10, 0, 1, 32'h1234_5678, "arst_ram_wr");
    cyc(0, 32'h10, 1, 0, 0, "arst_ram_rd");
    cyc(1, 32'h10, 1, 0, 0, "post_rst_ram");
    cyc(1, A_TL, 1, 0, 0, "post_rst_tl");
    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      rd = 1'($urandom);
      wr = 1'($urandom);
      wd = $urandom;
      if ($urandom_range(0, 9) < 3) begin
        a = {2'b00, 20'($urandom), 8'($urandom_range(0, 15)), 2'($urandom)};
        if (!m_ram.exists(ram_index(a))) rd = 1'b0;
      end else begin
        a = addrs[$urandom_range(0, 9)] | 32'($urandom_range(0, 3));
        if ((a & 32'hFFFF_FFFC) == A_TL && $urandom_range(0, 1) == 1)
          wd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        if ((a & 32'hFFFF_FFFC) == A_TCON) wd = 32'($urandom_range(0, 7));
      end
      cyc($urandom_range(0, 59) != 0, a, rd, wr, wd, "rand");
      if ($urandom_range(0, 7) == 0) iSwitch = 8'($urandom);
    end
    cyc(1, A_TCON, 1, 0, 0, "final_tcon");
    cyc(1, A_TICK, 1, 0, 0, "final_tick");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
